// File: rtl/irq_vector_ctrl.sv
// Interrupt aggregator: edge-latched sources, per-source mask, global enable, registered level irq, byte-wide register window.
// Latency: src edge -> irq 2 clk, ACK write -> irq drop 1 clk after the write; reads are side-effect free.
// Optional macro IRQ_LEVEL_MODE_EN adds the LEVEL register (offset E) making sources 0..7 level-sensitive.
module irq_vector_ctrl #(
    parameter int          NUM_SRC   = 8,
    parameter logic [15:0] BASE_ADDR = 16'hDF00
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src,
    input  logic [15:0]        address,
    input  logic [7:0]         data_i,
    input  logic               write,
    input  logic               ready,
    output logic               sel,
    output logic [7:0]         data_o,
    output logic               irq
);

    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] pend_q;
    logic [NUM_SRC-1:0] mask_q;
    logic [NUM_SRC-1:0] lvl_sel;
    logic [NUM_SRC-1:0] pend_eff;
    logic [NUM_SRC-1:0] act;
    logic [NUM_SRC-1:0] pend_nxt;
    logic [NUM_SRC-1:0] mask_nxt;
    logic [NUM_SRC-1:0] ack_clr;
    logic               ctrl_en;
    logic [3:0]         off;
    logic               we;
    logic [4:0]         idx;
    logic               any;

    assign off = address[3:0];
    assign sel = (address[15:4] == BASE_ADDR[15:4]);
    assign we  = sel & write & ready;

`ifdef IRQ_LEVEL_MODE_EN
    logic [7:0] level_q;

    always_comb begin
        lvl_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (i < 8) lvl_sel[i] = level_q[i % 8];
        end
    end
`else
    assign lvl_sel = '0;
`endif

    // Level-sensitive bits track src directly; edge bits come from the latch.
    assign pend_eff = (pend_q & ~lvl_sel) | (src & lvl_sel);
    assign act      = pend_eff & mask_q;

    always_comb begin
        mask_nxt = mask_q;
        ack_clr  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (we && off == 4'(4 + i / 8)) mask_nxt[i] = data_i[i % 8];
            if (we && off == 4'(8 + i / 8)) ack_clr[i]  = data_i[i % 8];
        end
        // New edge beats a simultaneous ACK.
        pend_nxt = ((pend_q & ~ack_clr) | (src & ~src_q)) & ~lvl_sel;
    end

    always_comb begin
        idx = 5'd0;
        any = |act;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (act[i]) idx = 5'(i);
        end
    end

    always_comb begin
        data_o = 8'h00;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (off == 4'(i / 8))     data_o[i % 8] = pend_eff[i];
            if (off == 4'(4 + i / 8)) data_o[i % 8] = mask_q[i];
        end
        case (off)
            4'hC:    data_o = {any, 2'b00, idx};
            4'hD:    data_o = {7'b0, ctrl_en};
`ifdef IRQ_LEVEL_MODE_EN
            4'hE:    data_o = level_q;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        src_q <= src;
        if (!reset) begin
            pend_q  <= '0;
            mask_q  <= '0;
            ctrl_en <= 1'b0;
            irq     <= 1'b0;
`ifdef IRQ_LEVEL_MODE_EN
            level_q <= 8'h00;
`endif
        end else begin
            pend_q <= pend_nxt;
            mask_q <= mask_nxt;
            irq    <= ctrl_en & (|act);
            if (we && off == 4'hD) ctrl_en <= data_i[0];
`ifdef IRQ_LEVEL_MODE_EN
            if (we && off == 4'hE) level_q <= data_i;
`endif
        end
    end

endmodule
